// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - memory-op encodings, access-size helpers and FSM state type for mem_stage
package cpu_mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Codes 9-15 fall through both predicates, so they behave as MEM_NONE.
  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [3:0] op);
    logic [1:0] sz;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: sz = SZ_BYTE;
      MEM_LH, MEM_LHU, MEM_SH: sz = SZ_HALF;
      default:                 sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
    logic m;
    case (op_size(op))
      SZ_HALF: m = lo[0];
      SZ_WORD: m = (lo != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  // Clears the low address bits below the access size (natural alignment).
  function automatic logic [1:0] align_lo(input logic [3:0] op, input logic [1:0] lo);
    logic [1:0] a;
    case (op_size(op))
      SZ_HALF: a = {lo[1], 1'b0};
      SZ_WORD: a = 2'b00;
      default: a = lo;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/half of a load word and sign- or zero-extends it
module load_align
  import cpu_mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [3:0]  i_op,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_data = i_rdata;
    case (i_op)
      MEM_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      MEM_LBU: o_data = {24'h000000, w_byte};
      MEM_LH:  o_data = {{16{w_half[15]}}, w_half};
      MEM_LHU: o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: byte/half/word loads and stores over a valid/ready bus
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing natural alignment.
module mem_stage
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_we_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [3:0]        mem_op_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic              stall_o,
  output logic              dbus_valid,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_wstrb,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_ready,
  input  logic [DATA_W-1:0] dbus_rdata,
  output logic              rd_we,
  output logic [4:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              misalign_o
);

  mem_state_e r_state;
  mem_state_e w_state_nxt;

  logic              r_dbus_valid;
  logic              r_dbus_we;
  logic [ADDR_W-1:0] r_dbus_addr;
  logic [3:0]        r_dbus_wstrb;
  logic [DATA_W-1:0] r_dbus_wdata;
  logic              r_rd_we;
  logic [4:0]        r_rd_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_misalign;
  logic [3:0]        r_op;
  logic [1:0]        r_addr_lo;
  logic [4:0]        r_acc_rd;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_misalign;
  logic              w_issue;
  logic              w_stall;
  logic [1:0]        w_lo_eff;
  logic [3:0]        w_wstrb;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_load_data;

  assign w_is_load  = is_load(mem_op_i);
  assign w_is_store = is_store(mem_op_i);
  assign w_lo_eff   = align_lo(mem_op_i, rd_data_i[1:0]);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = (w_is_load | w_is_store) & is_misaligned(mem_op_i, rd_data_i[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue = (w_is_load | w_is_store) & ~w_misalign;

  // Store lane steering; loads drive no strobes.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = st_data_i;
    case (op_size(mem_op_i))
      SZ_BYTE: begin
        w_wstrb = 4'b0001 << w_lo_eff;
        w_wdata = {4{st_data_i[7:0]}};
      end
      SZ_HALF: begin
        w_wstrb = w_lo_eff[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{st_data_i[15:0]}};
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = st_data_i;
      end
    endcase
    if (!w_is_store) begin
      w_wstrb = 4'b0000;
    end
  end

  load_align u_load_align (
    .i_rdata   (dbus_rdata),
    .i_addr_lo (r_addr_lo),
    .i_op      (r_op),
    .o_data    (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_stall     = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (dbus_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Reset masks the stall so upstream sees a quiet stage while rst is held.
  assign stall_o = w_stall & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbus_valid <= 1'b0;
      r_dbus_we    <= 1'b0;
      r_dbus_addr  <= '0;
      r_dbus_wstrb <= 4'b0000;
      r_dbus_wdata <= '0;
      r_rd_we      <= 1'b0;
      r_rd_addr    <= 5'd0;
      r_rd_data    <= '0;
      r_misalign   <= 1'b0;
      r_op         <= MEM_NONE;
      r_addr_lo    <= 2'b00;
      r_acc_rd     <= 5'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_misalign <= w_misalign;
          if (w_issue) begin
            r_dbus_valid <= 1'b1;
            r_dbus_we    <= w_is_store;
            r_dbus_addr  <= {rd_data_i[ADDR_W-1:2], 2'b00};
            r_dbus_wstrb <= w_wstrb;
            r_dbus_wdata <= w_wdata;
            r_op         <= mem_op_i;
            r_addr_lo    <= w_lo_eff;
            r_acc_rd     <= rd_addr_i;
            r_rd_we      <= 1'b0;
          end else if (w_misalign) begin
            r_rd_we <= 1'b0;
          end else begin
            r_rd_we   <= rd_we_i & (rd_addr_i != 5'd0);
            r_rd_addr <= rd_addr_i;
            r_rd_data <= rd_data_i;
          end
        end
        ST_BUSY: begin
          r_misalign <= 1'b0;
          if (dbus_ready) begin
            r_dbus_valid <= 1'b0;
            r_dbus_we    <= 1'b0;
            r_dbus_wstrb <= 4'b0000;
            if (is_load(r_op)) begin
              r_rd_we   <= (r_acc_rd != 5'd0);
              r_rd_addr <= r_acc_rd;
              r_rd_data <= w_load_data;
            end else begin
              r_rd_we <= 1'b0;
            end
          end
        end
        default: r_dbus_valid <= 1'b0;
      endcase
    end
  end

  assign dbus_valid = r_dbus_valid;
  assign dbus_we    = r_dbus_we;
  assign dbus_addr  = r_dbus_addr;
  assign dbus_wstrb = r_dbus_wstrb;
  assign dbus_wdata = r_dbus_wdata;
  assign rd_we      = r_rd_we;
  assign rd_addr    = r_rd_addr;
  assign rd_data    = r_rd_data;
  assign misalign_o = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage (honours MEM_MISALIGN_TRAP_EN)
module tb_mem_stage;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LW   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_we_i = 1'b0;
  logic [4:0]  rd_addr_i = 5'd0;
  logic [31:0] rd_data_i = 32'd0;
  logic [3:0]  mem_op_i = 4'd0;
  logic [31:0] st_data_i = 32'd0;
  logic        dbus_ready = 1'b0;
  logic [31:0] dbus_rdata = 32'd0;
  logic        stall_o, dbus_valid, dbus_we, rd_we, misalign_o;
  logic [31:0] dbus_addr, dbus_wdata, rd_data;
  logic [3:0]  dbus_wstrb;
  logic [4:0]  rd_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_we_i    (rd_we_i),
    .rd_addr_i  (rd_addr_i),
    .rd_data_i  (rd_data_i),
    .mem_op_i   (mem_op_i),
    .st_data_i  (st_data_i),
    .stall_o    (stall_o),
    .dbus_valid (dbus_valid),
    .dbus_we    (dbus_we),
    .dbus_addr  (dbus_addr),
    .dbus_wstrb (dbus_wstrb),
    .dbus_wdata (dbus_wdata),
    .dbus_ready (dbus_ready),
    .dbus_rdata (dbus_rdata),
    .rd_we      (rd_we),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .misalign_o (misalign_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic [3:0] op, input logic [31:0] st);
    rd_we_i   = we;
    rd_addr_i = rd;
    rd_data_i = d;
    mem_op_i  = op;
    st_data_i = st;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, OP_NONE, 32'd0);
    tick();
    tick();
    n_tests++; if ({rd_we, rd_addr, rd_data} !== 38'd0) begin n_fail++; $display("FAIL reset_rd: got %0b/%0d/%h expected 0/0/0", rd_we, rd_addr, rd_data); end
    n_tests++; if ({dbus_valid, dbus_we, dbus_wstrb, stall_o, misalign_o} !== 8'd0) begin n_fail++; $display("FAIL reset_ctl: got %b expected 0", {dbus_valid, dbus_we, dbus_wstrb, stall_o, misalign_o}); end
    n_tests++; if ({dbus_addr, dbus_wdata} !== 64'd0) begin n_fail++; $display("FAIL reset_bus: got %h/%h expected 0/0", dbus_addr, dbus_wdata); end
    rst = 1'b0;
    drive(1'b1, 5'd5, 32'h1234, OP_NONE, 32'd0);
    #1;
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL none_stall: got %0b expected 0", stall_o); end
    tick();
    n_tests++; if ({rd_we, rd_addr, rd_data} !== {1'b1, 5'd5, 32'h1234}) begin n_fail++; $display("FAIL none_pass: got %0b/%0d/%h expected 1/5/00001234", rd_we, rd_addr, rd_data); end
  endtask

  task automatic test_lb_wait();
    int stalls;
    stalls = 0;
    drive(1'b1, 5'd7, 32'h103, OP_LB, 32'd0);
    #1;
    if (stall_o) stalls++;
    tick();
    n_tests++; if ({dbus_valid, dbus_we, dbus_addr} !== {1'b1, 1'b0, 32'h100}) begin n_fail++; $display("FAIL lb_req: got v=%0b we=%0b a=%h expected 1/0/00000100", dbus_valid, dbus_we, dbus_addr); end
    n_tests++; if (rd_we !== 1'b0) begin n_fail++; $display("FAIL lb_bubble: got %0b expected 0", rd_we); end
    for (int i = 0; i < 3; i++) begin
      if (stall_o) stalls++;
      tick();
    end
    n_tests++; if (dbus_valid !== 1'b1) begin n_fail++; $display("FAIL lb_hold: got %0b expected 1", dbus_valid); end
    dbus_ready = 1'b1;
    dbus_rdata = 32'h80FF_0000;
    #1;
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL lb_ready_stall: got %0b expected 0", stall_o); end
    n_tests++; if (stalls !== 4) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d expected 4", stalls); end
    tick();
    dbus_ready = 1'b0;
    drive(1'b0, 5'd0, 32'd0, OP_NONE, 32'd0);
    n_tests++; if ({rd_we, rd_addr, rd_data} !== {1'b1, 5'd7, 32'hFFFF_FF80}) begin n_fail++; $display("FAIL lb_result: got %0b/%0d/%h expected 1/7/ffffff80", rd_we, rd_addr, rd_data); end
    n_tests++; if (dbus_valid !== 1'b0) begin n_fail++; $display("FAIL lb_release: got %0b expected 0", dbus_valid); end
    tick();
  endtask

  task automatic test_sh_store();
    drive(1'b1, 5'd9, 32'h202, OP_SH, 32'hABCD_1234);
    tick();
    n_tests++; if ({dbus_valid, dbus_we, dbus_addr} !== {1'b1, 1'b1, 32'h200}) begin n_fail++; $display("FAIL sh_req: got v=%0b we=%0b a=%h expected 1/1/00000200", dbus_valid, dbus_we, dbus_addr); end
    n_tests++; if (dbus_wstrb !== 4'b1100) begin n_fail++; $display("FAIL sh_wstrb: got %b expected 1100", dbus_wstrb); end
    n_tests++; if (dbus_wdata !== 32'h1234_1234) begin n_fail++; $display("FAIL sh_wdata: got %h expected 12341234", dbus_wdata); end
    dbus_ready = 1'b1;
    tick();
    dbus_ready = 1'b0;
    drive(1'b0, 5'd0, 32'd0, OP_NONE, 32'd0);
    n_tests++; if ({rd_we, dbus_valid} !== 2'b00) begin n_fail++; $display("FAIL sh_done: got rd_we=%0b v=%0b expected 0/0", rd_we, dbus_valid); end
    tick();
    n_tests++; if (rd_we !== 1'b0) begin n_fail++; $display("FAIL sh_after: got %0b expected 0", rd_we); end
  endtask

  task automatic test_lhu();
    drive(1'b1, 5'd3, 32'h6, OP_LHU, 32'd0);
    tick();
    n_tests++; if (dbus_addr !== 32'h4) begin n_fail++; $display("FAIL lhu_addr: got %h expected 00000004", dbus_addr); end
    dbus_ready = 1'b1;
    dbus_rdata = 32'h8001_0000;
    tick();
    dbus_ready = 1'b0;
    drive(1'b0, 5'd0, 32'd0, OP_NONE, 32'd0);
    n_tests++; if ({rd_we, rd_addr, rd_data} !== {1'b1, 5'd3, 32'h0000_8001}) begin n_fail++; $display("FAIL lhu_result: got %0b/%0d/%h expected 1/3/00008001", rd_we, rd_addr, rd_data); end
  endtask

  task automatic test_misalign();
    drive(1'b1, 5'd4, 32'h101, OP_LW, 32'd0);
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL mis_stall: got %0b expected 0", stall_o); end
    tick();
    drive(1'b0, 5'd0, 32'd0, OP_NONE, 32'd0);
    n_tests++; if ({misalign_o, dbus_valid, rd_we} !== 3'b100) begin n_fail++; $display("FAIL mis_pulse: got m=%0b v=%0b we=%0b expected 1/0/0", misalign_o, dbus_valid, rd_we); end
    tick();
    n_tests++; if ({misalign_o, dbus_valid} !== 2'b00) begin n_fail++; $display("FAIL mis_clear: got m=%0b v=%0b expected 0/0", misalign_o, dbus_valid); end
`else
    n_tests++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL mis_stall: got %0b expected 1", stall_o); end
    tick();
    n_tests++; if ({dbus_valid, dbus_addr, misalign_o} !== {1'b1, 32'h100, 1'b0}) begin n_fail++; $display("FAIL mis_align: got v=%0b a=%h m=%0b expected 1/00000100/0", dbus_valid, dbus_addr, misalign_o); end
    dbus_ready = 1'b1;
    dbus_rdata = 32'hDEAD_BEEF;
    tick();
    dbus_ready = 1'b0;
    drive(1'b0, 5'd0, 32'd0, OP_NONE, 32'd0);
    n_tests++; if ({rd_we, rd_data} !== {1'b1, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL mis_load: got %0b/%h expected 1/deadbeef", rd_we, rd_data); end
`endif
  endtask

  task automatic test_reset_busy();
    drive(1'b1, 5'd6, 32'h40, OP_LW, 32'd0);
    tick();
    tick();
    n_tests++; if (dbus_valid !== 1'b1) begin n_fail++; $display("FAIL rb_busy: got %0b expected 1", dbus_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, OP_NONE, 32'd0);
    #1;
    n_tests++; if ({dbus_valid, stall_o} !== 2'b00) begin n_fail++; $display("FAIL rb_abandon: got v=%0b stall=%0b expected 0/0", dbus_valid, stall_o); end
    tick();
    drive(1'b1, 5'd8, 32'h10, OP_LW, 32'd0);
    tick();
    n_tests++; if ({dbus_valid, dbus_addr} !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL rb_reissue: got v=%0b a=%h expected 1/00000010", dbus_valid, dbus_addr); end
    dbus_ready = 1'b1;
    dbus_rdata = 32'h1234_5678;
    tick();
    dbus_ready = 1'b0;
    drive(1'b0, 5'd0, 32'd0, OP_NONE, 32'd0);
    n_tests++; if ({rd_we, rd_addr, rd_data} !== {1'b1, 5'd8, 32'h1234_5678}) begin n_fail++; $display("FAIL rb_load: got %0b/%0d/%h expected 1/8/12345678", rd_we, rd_addr, rd_data); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd0, 32'h2, OP_LH, 32'd0);
    tick();
    n_tests++; if (dbus_valid !== 1'b1) begin n_fail++; $display("FAIL x0_access: got %0b expected 1", dbus_valid); end
    dbus_ready = 1'b1;
    dbus_rdata = 32'h8001_0000;
    tick();
    dbus_ready = 1'b0;
    drive(1'b1, 5'd1, 32'h2, OP_LH, 32'd0);
    #1;
    n_tests++; if (rd_we !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %0b expected 0", rd_we); end
    n_tests++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %0b expected 1", stall_o); end
    tick();
    dbus_ready = 1'b1;
    tick();
    dbus_ready = 1'b0;
    drive(1'b0, 5'd1, 32'h1, OP_SB, 32'h0000_005A);
    #1;
    n_tests++; if ({rd_we, rd_data} !== {1'b1, 32'hFFFF_8001}) begin n_fail++; $display("FAIL lh_sext: got %0b/%h expected 1/ffff8001", rd_we, rd_data); end
    tick();
    n_tests++; if ({dbus_wstrb, dbus_wdata} !== {4'b0010, 32'h5A5A_5A5A}) begin n_fail++; $display("FAIL sb_lanes: got %b/%h expected 0010/5a5a5a5a", dbus_wstrb, dbus_wdata); end
    dbus_ready = 1'b1;
    tick();
    dbus_ready = 1'b0;
    drive(1'b1, 5'd2, 32'h77, 4'd9, 32'd0);
    #1;
    n_tests++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL op9_stall: got %0b expected 0", stall_o); end
    tick();
    n_tests++; if ({rd_we, rd_addr, rd_data, dbus_valid} !== {1'b1, 5'd2, 32'h77, 1'b0}) begin n_fail++; $display("FAIL op9_pass: got %0b/%0d/%h v=%0b expected 1/2/00000077/0", rd_we, rd_addr, rd_data, dbus_valid); end
    drive(1'b0, 5'd0, 32'd0, OP_NONE, 32'd0);
  endtask

  initial begin
    test_reset();
    test_lb_wait();
    test_sh_store();
    test_lhu();
    test_misalign();
    test_reset_busy();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
